// File: rtl/paddle.sv
// -----------------------------------------------------------------------------
// paddle
//   Player paddle for the ball game. Two raw push buttons are synchronised and
//   debounced. A small FSM (IDLE / LEFT / RIGHT / WALL) then steps the paddle's
//   left edge on each animation strobe while animation is enabled. A goal pulse
//   puts the paddle back at its home position.
//
//   Optional feature: define PADDLE_ACCEL_EN to enable acceleration. With it,
//   a 6-bit saturating counter counts consecutive strobes in the same move
//   state, and the step grows from 1 to 2 to 4 pixels. Without it the step is
//   always 1 pixel.
//
// Ports
//   i_clk        single clock for the whole block
//   i_rst_n      asynchronous, active-low reset
//   i_ani_stb    one-cycle animation strobe
//   i_animate    movement enable
//   i_btn_left   raw left button, active-high
//   i_btn_right  raw right button, active-high
//   i_goal       one-cycle goal pulse; returns the paddle home
//   o_x          paddle left edge
//   o_dir        0 = moving right, 1 = moving left, 2 = stationary
//   o_x1/o_x2    drawing box horizontal extent (o_x, o_x+PW)
//   o_y1/o_y2    drawing box vertical extent (IY, IY+PH)
// -----------------------------------------------------------------------------
module paddle #(
    parameter int PW        = 100,
    parameter int PH        = 10,
    parameter int IX        = 270,
    parameter int IY        = 450,
    parameter int D_WIDTH   = 640,
    parameter int DB_CYCLES = 250000
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_ani_stb,
    input  logic        i_animate,
    input  logic        i_btn_left,
    input  logic        i_btn_right,
    input  logic        i_goal,
    output logic [11:0] o_x,
    output logic [1:0]  o_dir,
    output logic [11:0] o_x1,
    output logic [11:0] o_x2,
    output logic [11:0] o_y1,
    output logic [11:0] o_y2
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LEFT  = 2'd1,
        RIGHT = 2'd2,
        WALL  = 2'd3
    } state_t;

    localparam int          DB_W     = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
    localparam logic [11:0] LP_IX    = 12'(IX);
    localparam logic [11:0] LP_LIMIT = 12'(D_WIDTH - PW);
    localparam logic [11:0] LP_PW    = 12'(PW);
    localparam logic [11:0] LP_IY    = 12'(IY);
    localparam logic [11:0] LP_PH    = 12'(PH);

    // Index 0 = left button, index 1 = right button.
    logic [1:0]      w_raw;
    logic [1:0]      r_meta;
    logic [1:0]      r_sync;
    logic [1:0]      r_db;
    logic [DB_W-1:0] r_db_cnt [2];

    state_t          r_state;
    state_t          w_next_state;
    logic [11:0]     r_x;
    logic [11:0]     w_next_x;
    logic [11:0]     w_step;
    logic            w_move;

    assign w_raw  = {i_btn_right, i_btn_left};
    assign w_move = i_ani_stb & i_animate;

    // Two-flop synchroniser followed by a debouncer for each button. The
    // counter runs only while the synchronised level disagrees with the
    // debounced level. The debounced level flips on the DB_CYCLES-th
    // consecutive disagreeing cycle. Any agreeing cycle restarts the window.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_meta <= 2'b00;
            r_sync <= 2'b00;
            r_db   <= 2'b00;
            for (int b = 0; b < 2; b++) begin
                r_db_cnt[b] <= '0;
            end
        end else begin
            r_meta <= w_raw;
            r_sync <= r_meta;
            for (int b = 0; b < 2; b++) begin
                if (r_sync[b] != r_db[b]) begin
                    if (r_db_cnt[b] == DB_W'(DB_CYCLES - 1)) begin
                        r_db[b]     <= r_sync[b];
                        r_db_cnt[b] <= '0;
                    end else begin
                        r_db_cnt[b] <= r_db_cnt[b] + DB_W'(1);
                    end
                end else begin
                    r_db_cnt[b] <= '0;
                end
            end
        end
    end

`ifdef PADDLE_ACCEL_EN
    logic [5:0] r_accel;
    logic [5:0] w_next_accel;

    // The count is the number of strobes already spent in the current move
    // state. Counts 16-31 have bit 4 set, and counts from 32 on have bit 5 set.
    assign w_step = r_accel[5] ? 12'd4 : (r_accel[4] ? 12'd2 : 12'd1);
`else
    assign w_step = 12'd1;
`endif

    // State register. A goal has priority over movement and does not wait
    // for a strobe. Otherwise the state and position advance together, and
    // only on a qualifying strobe.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= IDLE;
            r_x     <= LP_IX;
`ifdef PADDLE_ACCEL_EN
            r_accel <= 6'd0;
`endif
        end else if (i_goal) begin
            r_state <= IDLE;
            r_x     <= LP_IX;
`ifdef PADDLE_ACCEL_EN
            r_accel <= 6'd0;
`endif
        end else if (w_move) begin
            r_state <= w_next_state;
            r_x     <= w_next_x;
`ifdef PADDLE_ACCEL_EN
            r_accel <= w_next_accel;
`endif
        end
    end

    // Next-state logic. This block only decides; the register above applies
    // the result on a qualifying strobe. A request that starts at the limit
    // in its direction goes to WALL. A move that clamps onto the limit in
    // this strobe still counts as LEFT or RIGHT. The subtraction is guarded
    // against unsigned underflow.
    always_comb begin
        w_next_state = IDLE;
        w_next_x     = r_x;
        if (r_db[0] && !r_db[1]) begin
            if (r_x == 12'd0) begin
                w_next_state = WALL;
            end else begin
                w_next_state = LEFT;
                w_next_x     = (r_x > w_step) ? (r_x - w_step) : 12'd0;
            end
        end else if (r_db[1] && !r_db[0]) begin
            if (r_x >= LP_LIMIT) begin
                w_next_state = WALL;
            end else begin
                w_next_state = RIGHT;
                w_next_x     = ((LP_LIMIT - r_x) > w_step) ? (r_x + w_step) : LP_LIMIT;
            end
        end
    end

`ifdef PADDLE_ACCEL_EN
    // Entering a move state (from IDLE, from WALL or by reversal) restarts
    // the count at 1. Staying in the same move state increments it up to
    // the saturation value.
    always_comb begin
        w_next_accel = 6'd0;
        if (w_next_state == LEFT || w_next_state == RIGHT) begin
            if (w_next_state == r_state) begin
                w_next_accel = (r_accel == 6'd63) ? 6'd63 : (r_accel + 6'd1);
            end else begin
                w_next_accel = 6'd1;
            end
        end
    end
`endif

    // Output decode. Both IDLE and WALL report a stationary paddle.
    always_comb begin
        o_dir = 2'd2;
        case (r_state)
            LEFT:    o_dir = 2'd1;
            RIGHT:   o_dir = 2'd0;
            default: o_dir = 2'd2;
        endcase
    end

    assign o_x  = r_x;
    assign o_x1 = r_x;
    assign o_x2 = r_x + LP_PW;
    assign o_y1 = LP_IY;
    assign o_y2 = LP_IY + LP_PH;

endmodule

// File: doc/paddle.md
PADDLE -- requirements
Module: paddle

Interface
REQ-001 Parameter PW, 100: paddle width in pixels.
REQ-002 Parameter PH, 10: paddle height in pixels.
REQ-003 Parameter IX, 270: reset/goal left-edge x position.
REQ-004 Parameter IY, 450: fixed paddle top-edge y position.
REQ-005 Parameter D_WIDTH, 640: display width; legal left edge is 0..D_WIDTH-PW.
REQ-006 Parameter DB_CYCLES, 250000: debounce stability window in i_clk cycles.
REQ-007 i_clk  input  1  base clock; the block uses this single clock only.
REQ-008 i_rst_n  input  1  reset, asynchronous, active-low.
REQ-009 i_ani_stb  input  1  animation strobe, one i_clk cycle wide.
REQ-010 i_animate  input  1  movement is enabled while high.
REQ-011 i_btn_left, i_btn_right  input  1 each  raw, unsynchronised push buttons, active-high.
REQ-012 i_goal  input  1  one-cycle goal pulse from the ball block.
REQ-013 o_x  output  12  paddle left edge; feeds ball i_paddle_*_x.
REQ-014 o_dir  output  2  motion code: 0=moving right, 1=moving left, 2=stationary; feeds ball i_paddle_*_dir.
REQ-015 o_x1/o_x2/o_y1/o_y2  output  12 each  drawing box: o_x, o_x+PW, IY, IY+PH.

Function
REQ-016 Each button SHALL pass through a 2-flop synchroniser, then a debouncer whose output changes only after the synchronised level has been stable for DB_CYCLES consecutive i_clk cycles.
REQ-017 The FSM SHALL have states IDLE, LEFT, RIGHT, WALL; o_dir is 2 in IDLE and WALL, 1 in LEFT, 0 in RIGHT.
REQ-018 FSM transitions and position updates SHALL occur only on cycles with i_ani_stb=1 and i_animate=1; at all other times state, o_x and o_dir hold.
REQ-019 Request: left-only debounced -> move left; right-only -> move right; none or both -> IDLE.
REQ-020 Move left SHALL set o_x to max(o_x-step, 0) without unsigned underflow; move right SHALL set o_x to min(o_x+step, D_WIDTH-PW).
REQ-021 If a move request starts at the limit in its direction, the state SHALL be WALL and o_x unchanged; a move that reaches the limit in that strobe is still LEFT/RIGHT.
REQ-022 o_x and o_dir SHALL update in the same i_clk edge, registered, one cycle after the qualifying strobe.
REQ-023 step SHALL be 1 pixel when PADDLE_ACCEL_EN is undefined.
REQ-024 i_goal=1 SHALL, on that edge regardless of strobe, set o_x=IX, state IDLE, and clear the acceleration counter; it has priority over movement.
REQ-025 A direction reversal SHALL take effect on the first qualifying strobe; there is no intermediate IDLE frame.

Reset
REQ-026 While i_rst_n=0: o_x=IX, state IDLE (o_dir=2), synchroniser and debounce flops 0, debounce counters 0, acceleration counter 0.
REQ-027 Reset assertion mid-move SHALL take effect immediately, asynchronously; after release, the block waits a full debounce window before it recognises a held button.

Configuration
REQ-028 Macro PADDLE_ACCEL_EN: when defined, a 6-bit saturating counter SHALL count consecutive strobes in the same move state.
REQ-029 With the macro defined, step SHALL be 1 for counts 0-15, 2 for counts 16-31, and 4 from 32 on; the counter clears on IDLE, WALL, reversal or goal.
REQ-030 Without the macro, the counter SHALL be absent and step SHALL be fixed at 1.

Verification (DB_CYCLES=4, i_animate=1, strobe every 10 clk)
REQ-031 Reset released, no buttons, 5 strobes -> o_x=270 and o_dir=2 throughout.
REQ-032 i_btn_right held for 10 strobes after debounce -> o_x=280, o_dir=0; released -> o_dir=2 on the next strobe and o_x holds at 280.
REQ-033 Left held from o_x=3 -> o_x sequence 2,1,0 with o_dir=1, then o_dir=2 (WALL) with o_x=0 thereafter.
REQ-034 A 2-cycle glitch on i_btn_left -> no change in o_x or o_dir.
REQ-035 Both buttons held -> o_dir=2 and o_x unchanged; i_goal pulse while moving at o_x=400 -> o_x=270, o_dir=2 on the next edge.
REQ-036 PADDLE_ACCEL_EN defined, right held from 270 for 40 strobes -> o_x=270+16+32+32=350.
